// File: rtl/riscv_pipe_pkg.sv
// rtl/riscv_pipe_pkg.sv - shared pipeline types for the 5-stage RISC-V core
package riscv_pipe_pkg;

  localparam logic [1:0] RES_LOAD = 2'b01;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    HZ_IDLE = 2'b00,
    HZ_WAIT = 2'b01,
    HZ_ERR  = 2'b10
  } hz_state_t;

  // MEM wins over WB so the youngest producer is forwarded.
  function automatic fwd_sel_t fwd_select(
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic       wr_m,
    input logic [4:0] rd_w,
    input logic       wr_w
  );
    if (wr_m && rd_m == rs && rs != 5'd0)      return FWD_MEM;
    else if (wr_w && rd_w == rs && rs != 5'd0) return FWD_WB;
    else                                       return FWD_RF;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && count_q != '1) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush/forward control with data-memory wait FSM
module hazard_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic [1:0]       ResultSrcE,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             dmem_ready,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int              WCW      = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCW-1:0]  WAIT_MAX = WCW'(MEM_TIMEOUT);

  hz_state_t      state_q;
  logic [WCW-1:0] wait_cnt_q;
  logic           mem_err_q;

  logic mem_stall;
  logic lw_stall;
  logic br_flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= HZ_IDLE;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      case (state_q)
        HZ_IDLE: begin
          if (MemReqM && !dmem_ready) begin
            state_q    <= HZ_WAIT;
            wait_cnt_q <= WCW'(1);
          end
        end
        HZ_WAIT: begin
          if (dmem_ready) begin
            state_q    <= HZ_IDLE;
            wait_cnt_q <= '0;
          end else if (wait_cnt_q == WAIT_MAX) begin
            state_q   <= HZ_ERR;
            mem_err_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q   <= HZ_ERR;
          mem_err_q <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    mem_stall = 1'b1;
    case (state_q)
      HZ_IDLE: mem_stall = MemReqM & ~dmem_ready;
      HZ_WAIT: mem_stall = ~dmem_ready;
      default: mem_stall = 1'b1;
    endcase
  end

  assign lw_stall = (ResultSrcE == RES_LOAD) && (RdE != 5'd0) &&
                    ((RdE == Rs1D) || (RdE == Rs2D));

  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    br_flush  = 1'b0;
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    if (reset) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else begin
      ForwardAE = fwd_select(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
      ForwardBE = fwd_select(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
      // A memory stall freezes the whole pipe, so a pending branch must wait too.
      if (mem_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
      end else if (PCSrcE) begin
        FlushD   = 1'b1;
        FlushE   = 1'b1;
        br_flush = 1'b1;
      end else if (lw_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  assign mem_err = mem_err_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (StallF),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (br_flush),
    .count (flush_cnt)
  );

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage RISC-V core. Produces the stall enables and flush/clear strobes consumed by the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus the EX-stage operand-forwarding selects. Adds a data-memory wait FSM with timeout. Exposes saturating stall and flush performance counters.

## Interface
- MEM_TIMEOUT, 16: max WAIT-state cycles before ERR (≥1)
- CNT_W, 32: performance counter width
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- Rs1D, Rs2D  in  5 each  source regs of instruction in ID
- Rs1E, Rs2E, RdE  in  5 each  source/dest regs in EX
- RdM, RdW  in  5 each  dest regs in MEM / WB
- RegWriteM, RegWriteW  in  1  writeback enables in MEM / WB
- ResultSrcE  in  2  result select in EX; 2'b01 = load
- PCSrcE  in  1  taken branch/jump resolved in EX
- MemReqM  in  1  load/store in MEM issuing to data memory
- dmem_ready  in  1  data memory completes access this cycle
- StallF, StallD, StallE, StallM  out  1  hold PC / IF-ID / ID-EX / EX-MEM
- FlushD, FlushE  out  1  clear IF-ID / ID-EX
- ForwardAE, ForwardBE  out  2  00 regfile, 01 WB result, 10 MEM ALU result
- mem_err  out  1  sticky timeout error
- stall_cnt, flush_cnt  out  CNT_W  saturating counters

## Operation
- Forwarding (combinational), per operand X∈{1,2}: 10 if RegWriteM & RdM==RsXE & RsXE!=0; else 01 if RegWriteW & RdW==RsXE & RsXE!=0; else 00. MEM beats WB.
- lwStall = (ResultSrcE==2'b01) & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).
- memStall: IDLE: MemReqM & !dmem_ready; WAIT: !dmem_ready; ERR: 1.
- Priority, highest first:
  - reset: all stalls 0, FlushD=FlushE=1, Forward=00.
  - memStall: StallF/D/E/M=1, FlushD=FlushE=0, lwStall ignored.
  - PCSrcE: FlushD=FlushE=1, StallF=StallD=0 (overrides lwStall).
  - lwStall: StallF=StallD=1, FlushE=1, FlushD=0.
  - else: all 0.
- StallE/StallM assert only for memStall.
- FSM states IDLE, WAIT, ERR; wait_cnt ⌈log2(MEM_TIMEOUT+1)⌉ bits.
  - IDLE: MemReqM & !dmem_ready → WAIT, wait_cnt=1; else stay.
  - WAIT: dmem_ready → IDLE, wait_cnt=0; else if wait_cnt==MEM_TIMEOUT → ERR; else wait_cnt+1.
  - ERR: mem_err=1, full stall, exit only via reset.
- stall_cnt +1 per cycle with StallF=1. flush_cnt +1 per cycle with PCSrcE-caused flush. Both saturate at all-ones, no wrap.

## Timing
- Forward/stall/flush outputs combinational from inputs and current state, same cycle; no added latency.
- FSM, wait_cnt, mem_err, counters update on posedge clk.
- Reset: state IDLE, wait_cnt 0, mem_err 0, counters 0.
- Access ready in the request cycle: zero stall. First ready in WAIT: that cycle unstalled, IDLE next edge.
- Stall cycles before ERR: MEM_TIMEOUT+1 (one IDLE, MEM_TIMEOUT WAIT). ERR from next edge.
- Reset mid-WAIT/ERR: immediate IDLE, stalls drop asynchronously.
- Counter already at max: holds.

## Structure
- Shared package riscv_pipe_pkg: RES_LOAD=2'b01; fwd_sel_t (FWD_RF, FWD_WB, FWD_MEM); hz_state_t (HZ_IDLE, HZ_WAIT, HZ_ERR).
- Sub-module sat_counter (params W; in clk, reset, inc; out count), instantiated for stall_cnt and flush_cnt.
- FSM and hazard logic live in hazard_ctrl itself.

## Test plan
- RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5 → ForwardAE=10; Rs1E=0, same writers → 00.
- ResultSrcE=01, RdE=7, Rs2D=7 → StallF=StallD=FlushE=1, FlushD=0; stall_cnt +1 per cycle.
- Same load-use with PCSrcE=1 → FlushD=FlushE=1, StallF=StallD=0; flush_cnt +1.
- MEM_TIMEOUT=4: MemReqM=1, dmem_ready=0 for 3 cycles then 1 → StallF/D/E/M high 3 cycles, low on ready cycle, IDLE next; PCSrcE=1 in that window → no flush.
- MEM_TIMEOUT=4, dmem_ready held 0 → 5 stalled cycles, ERR; mem_err=1 and stalls stay high; assert reset → mem_err=0, IDLE, counters 0.
- CNT_W=4: hold lwStall 20 cycles → stall_cnt reaches 15 and holds.
